// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: repeat FSM states and default clock/timing constants
// for the push-button front end.
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_t;

  localparam int DEFAULT_CLK_HZ       = 50000000;
  localparam int DEFAULT_DEB_CYCLES   = 500000;
  localparam int DEFAULT_REPEAT_DELAY = 25000000;
  localparam int DEFAULT_REPEAT_RATE  = 5000000;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release edges and,
// when BTN_AUTOREPEAT_EN is defined, the auto-repeat FSM.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int DEB_CYCLES     = DEFAULT_DEB_CYCLES,
  parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEFAULT_REPEAT_RATE,
  parameter int BTN_ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          settle;

  assign differ = sync_p1 ^ level;
  // The counter is allowed to sit at DEB_CYCLES for one cycle before the level flips.
  assign settle = differ && (cnt == CW'(DEB_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      // stage p0/p1: synchroniser with polarity folded in ahead of it
      sync_p0 <= raw ^ (BTN_ACTIVE_LOW != 0);
      sync_p1 <= sync_p0;
      // debounce stage: edges are registered alongside the level change
      press   <= settle && !level;
      rel     <= settle && level;
      if (settle) begin
        level <= ~level;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  rpt_state_t    state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          rpt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      rpt   <= rpt_nx;
    end
  end

  // A release settling in the same cycle as timer expiry suppresses the repeat.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    rpt_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (settle && !level) begin
          state_nx = DELAY;
          timer_nx = TW'(REPEAT_DELAY - 1);
        end
      end
      DELAY, RPT: begin
        if (settle && level) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (timer == '0) begin
          rpt_nx   = 1'b1;
          state_nx = RPT;
          timer_nx = TW'(REPEAT_RATE - 1);
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button front end: one btn_debounce per channel. Auto-repeat is
// built only when BTN_AUTOREPEAT_EN is defined; otherwise btn_repeat is tied low.
module btn_conditioner
  import board_io_pkg::*;
#(
  parameter int N_BTN          = 5,
  parameter int DEB_CYCLES     = DEFAULT_DEB_CYCLES,
  parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEFAULT_REPEAT_RATE,
  parameter int BTN_ACTIVE_LOW = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE),
      .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_ch (
      .clk  (sys_clk),
      .rst_n(sys_rst_n),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .rpt  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Repeat expectations follow whether BTN_AUTOREPEAT_EN is defined for the build.
module tb_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic [4:0] raw;
  logic [4:0] lvl, prs, rls, rpt;
  logic [4:0] raw_al;
  logic [4:0] lvl_al, prs_al, rls_al, rpt_al;

  int errors;
  int checks;

  btn_conditioner #(
    .N_BTN(5), .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .BTN_ACTIVE_LOW(0)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .btn_raw(raw),
    .btn_level(lvl), .btn_press(prs), .btn_release(rls), .btn_repeat(rpt)
  );

  btn_conditioner #(
    .N_BTN(5), .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .BTN_ACTIVE_LOW(1)
  ) dut_al (
    .sys_clk(clk), .sys_rst_n(rst_n), .btn_raw(raw_al),
    .btn_level(lvl_al), .btn_press(prs_al), .btn_release(rls_al), .btn_repeat(rpt_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Repeat pulse expected at tick i when the first repeat lands on tick 'first'.
  function automatic bit rpt_due(int i, int first);
`ifdef BTN_AUTOREPEAT_EN
    return (i >= first) && (((i - first) % 3) == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    logic [19:0] got;
    rst_n  = 1'b0;
    raw    = '0;
    raw_al = '1;
    #3;
    got = {lvl, prs, rls, rpt};
    checks++;
    if (got !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 00000", got);
    end
    tick();
    tick();
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {lvl_al, prs_al, rls_al, rpt_al};
      checks++;
      if (got !== 20'h0) begin
        errors++;
        $display("FAIL reset_idle_al tick %0d: got %h want 00000", i, got);
      end
      got = {lvl, prs, rls, rpt};
      checks++;
      if (got !== 20'h0) begin
        errors++;
        $display("FAIL reset_idle tick %0d: got %h want 00000", i, got);
      end
    end
  endtask

  task automatic test_press();
    logic [4:0] e_lvl, e_prs, e_rls, e_rpt;
    raw = 5'b00001;
    for (int i = 1; i <= 30; i++) begin
      tick();
      e_lvl = (i >= 7) ? 5'b00001 : 5'b00000;
      e_prs = (i == 7) ? 5'b00001 : 5'b00000;
      e_rpt = rpt_due(i, 17) ? 5'b00001 : 5'b00000;
      checks++;
      if (lvl !== e_lvl) begin
        errors++;
        $display("FAIL press_level tick %0d: got %b want %b", i, lvl, e_lvl);
      end
      checks++;
      if (prs !== e_prs) begin
        errors++;
        $display("FAIL press_pulse tick %0d: got %b want %b", i, prs, e_prs);
      end
      checks++;
      if (rpt !== e_rpt) begin
        errors++;
        $display("FAIL press_repeat tick %0d: got %b want %b", i, rpt, e_rpt);
      end
    end
    raw = 5'b00000;
    for (int j = 1; j <= 10; j++) begin
      tick();
      e_lvl = (j < 7) ? 5'b00001 : 5'b00000;
      e_rls = (j == 7) ? 5'b00001 : 5'b00000;
      e_rpt = ((j < 7) && rpt_due(30 + j, 17)) ? 5'b00001 : 5'b00000;
      checks++;
      if ({lvl, rls, prs} !== {e_lvl, e_rls, 5'b00000}) begin
        errors++;
        $display("FAIL release tick %0d: got lvl=%b rel=%b prs=%b want lvl=%b rel=%b prs=00000",
                 j, lvl, rls, prs, e_lvl, e_rls);
      end
      checks++;
      if (rpt !== e_rpt) begin
        errors++;
        $display("FAIL release_repeat tick %0d: got %b want %b", j, rpt, e_rpt);
      end
    end
  endtask

  task automatic test_glitch();
    raw = 5'b00100;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 3) raw = 5'b00000;
      checks++;
      if ({lvl, prs, rls, rpt} !== 20'h0) begin
        errors++;
        $display("FAIL glitch tick %0d: got lvl=%b prs=%b rel=%b rpt=%b want all 0",
                 i, lvl, prs, rls, rpt);
      end
    end
  endtask

  task automatic test_release_expiry();
    logic [4:0] e_lvl, e_prs, e_rls, e_rpt;
    raw = 5'b00010;
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (i == 13) raw = 5'b00000;
      e_lvl = (i >= 7 && i < 20) ? 5'b00010 : 5'b00000;
      e_prs = (i == 7) ? 5'b00010 : 5'b00000;
      e_rls = (i == 20) ? 5'b00010 : 5'b00000;
      e_rpt = (rpt_due(i, 17) && i < 20) ? 5'b00010 : 5'b00000;
      checks++;
      if ({lvl, prs, rls} !== {e_lvl, e_prs, e_rls}) begin
        errors++;
        $display("FAIL expiry_edges tick %0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                 i, lvl, prs, rls, e_lvl, e_prs, e_rls);
      end
      checks++;
      if (rpt !== e_rpt) begin
        errors++;
        $display("FAIL expiry_repeat tick %0d: got %b want %b", i, rpt, e_rpt);
      end
    end
  endtask

  task automatic test_active_low();
    logic [4:0] e_lvl, e_prs, e_rls;
    raw_al = 5'b10111;
    for (int i = 1; i <= 9; i++) begin
      tick();
      e_lvl = (i >= 7) ? 5'b01000 : 5'b00000;
      e_prs = (i == 7) ? 5'b01000 : 5'b00000;
      checks++;
      if ({lvl_al, prs_al, rls_al} !== {e_lvl, e_prs, 5'b00000}) begin
        errors++;
        $display("FAIL active_low_press tick %0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=00000",
                 i, lvl_al, prs_al, rls_al, e_lvl, e_prs);
      end
    end
    raw_al = 5'b11111;
    for (int j = 1; j <= 9; j++) begin
      tick();
      e_lvl = (j < 7) ? 5'b01000 : 5'b00000;
      e_rls = (j == 7) ? 5'b01000 : 5'b00000;
      checks++;
      if ({lvl_al, prs_al, rls_al} !== {e_lvl, 5'b00000, e_rls}) begin
        errors++;
        $display("FAIL active_low_release tick %0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=00000 rel=%b",
                 j, lvl_al, prs_al, rls_al, e_lvl, e_rls);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] e_lvl, e_prs;
    raw = 5'b10000;
    for (int i = 1; i <= 10; i++) tick();
    checks++;
    if (lvl !== 5'b10000) begin
      errors++;
      $display("FAIL hold_before_reset: got %b want 10000", lvl);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lvl, prs, rls, rpt} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset_drop: got lvl=%b prs=%b rel=%b rpt=%b want all 0",
               lvl, prs, rls, rpt);
    end
    tick();
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      e_lvl = (i >= 7) ? 5'b10000 : 5'b00000;
      e_prs = (i == 7) ? 5'b10000 : 5'b00000;
      checks++;
      if ({lvl, prs, rls, rpt} !== {e_lvl, e_prs, 10'b0}) begin
        errors++;
        $display("FAIL requalify tick %0d: got lvl=%b prs=%b rel=%b rpt=%b want lvl=%b prs=%b rel=00000 rpt=00000",
                 i, lvl, prs, rls, rpt, e_lvl, e_prs);
      end
    end
    raw = 5'b00000;
    for (int j = 1; j <= 10; j++) tick();
    checks++;
    if (lvl !== 5'b00000) begin
      errors++;
      $display("FAIL requalify_release: got %b want 00000", lvl);
    end
  endtask

  task automatic test_all_channels();
    logic [4:0] e_lvl, e_prs, e_rls, e_rpt;
    raw = 5'b11111;
    for (int i = 1; i <= 40; i++) begin
      tick();
      e_lvl = (i >= 7) ? 5'b11111 : 5'b00000;
      e_prs = (i == 7) ? 5'b11111 : 5'b00000;
      e_rpt = rpt_due(i, 17) ? 5'b11111 : 5'b00000;
      checks++;
      if ({lvl, prs, rls} !== {e_lvl, e_prs, 5'b00000}) begin
        errors++;
        $display("FAIL all_press tick %0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=00000",
                 i, lvl, prs, rls, e_lvl, e_prs);
      end
      checks++;
      if (rpt !== e_rpt) begin
        errors++;
        $display("FAIL all_repeat tick %0d: got %b want %b", i, rpt, e_rpt);
      end
    end
    raw = 5'b00000;
    for (int j = 1; j <= 10; j++) begin
      tick();
      e_lvl = (j < 7) ? 5'b11111 : 5'b00000;
      e_rls = (j == 7) ? 5'b11111 : 5'b00000;
      e_rpt = ((j < 7) && rpt_due(40 + j, 17)) ? 5'b11111 : 5'b00000;
      checks++;
      if ({lvl, prs, rls, rpt} !== {e_lvl, 5'b00000, e_rls, e_rpt}) begin
        errors++;
        $display("FAIL all_release tick %0d: got lvl=%b prs=%b rel=%b rpt=%b want lvl=%b prs=00000 rel=%b rpt=%b",
                 j, lvl, prs, rls, rpt, e_lvl, e_rls, e_rpt);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_press();
    test_glitch();
    test_release_expiry();
    test_active_low();
    test_reset_mid_hold();
    test_all_channels();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
